sr_latch_bank_arbiter: RTL and testbench
========================================

Name: sr_latch_bank_arbiter

Overview:
Shares one bank of NLAT active-low-enabled SR latches between NREQ requesters. Each requester asks to set or reset one latch index. A round-robin arbiter picks one request at a time. It then sequences a glitch-safe write: s/r set up with the enable closed, an enable-low window of PULSE cycles, then a hold cycle. The block guarantees the latch bank never sees s=r=1, and keeps a registered shadow of every latch state.

Parameters:
NREQ, 4, number of requesters (>=2)
NLAT, 8, number of latches in the bank (>=2)
IDXW, 3, latch index width, ceil(log2(NLAT))
PULSE, 2, cycles lat_en_n is held low per write (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  per-requester request, held high until granted
req_op  in  NREQ  per-requester op: 1=set, 0=reset
req_idx  in  NREQ*IDXW  per-requester target latch; requester k uses bits [k*IDXW +: IDXW]
gnt  out  NREQ  one-hot, one-cycle grant pulse
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse in HOLD
err  out  1  one-cycle pulse in SETUP when the granted index is >= NLAT
lat_s  out  NLAT  set lines to the latch bank
lat_r  out  NLAT  reset lines to the latch bank
lat_en_n  out  1  shared active-low latch enable
q_shadow  out  NLAT  tracked latch state

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; gnt=0, busy=0, done=0, err=0.
  - lat_s=0, lat_r=0, lat_en_n=1, q_shadow=0.
  - Round-robin pointer=0.
  - Asserting reset mid-operation aborts the write immediately: enable closes, s/r clear, shadow resets to 0.
- All outputs are registered.
- FSM states: IDLE -> SETUP -> PULSE -> HOLD -> IDLE.
- IDLE:
  - If any req bit is high, choose the first requester at or after the pointer, wrapping modulo NREQ.
  - Capture that requester's op and idx, then go to SETUP.
  - With no requests, stay in IDLE.
- SETUP (1 cycle):
  - gnt[k]=1 for this cycle only.
  - lat_en_n=1.
  - Drive lat_s[idx]=op and lat_r[idx]=~op; all other bits 0.
  - If idx>=NLAT: err=1, all s/r bits 0, and the write becomes a no-op that still runs the full sequence.
  - Pointer becomes (k+1) mod NREQ.
- PULSE (PULSE cycles, internal counter):
  - lat_en_n=0; s/r unchanged.
- HOLD (1 cycle):
  - lat_en_n=1; s/r still driven (hold time).
  - done=1.
  - q_shadow[idx] updates to op at the end of this cycle; not updated for an out-of-range idx.
- Return to IDLE:
  - lat_s and lat_r clear to 0 on entry.
  - IDLE lasts at least 1 cycle before the next SETUP.
- Latency and throughput:
  - Request seen in IDLE at cycle T -> gnt at T+1 -> done at T+2+PULSE.
  - Back-to-back write period is PULSE+3 cycles.
- Invariants:
  - lat_s & lat_r == 0 in every cycle.
  - At most one bit of lat_s|lat_r is set.
  - lat_s/lat_r never change while lat_en_n=0.
  - gnt is zero or one-hot.
- Requests arriving while busy are not sampled. The requester must keep req high until its gnt.
- A requester that drops req before being granted is simply skipped.
- Changes to req_op/req_idx after SETUP have no effect on the write in progress.
- Writing the value a latch already holds still runs the full sequence; q_shadow is unchanged.

Test Plan:
1. Single write: reset, then req[0]=1, op=1, idx=5 -> gnt=4'b0001 one cycle later; lat_s=8'h20 and lat_r=0 for 4 cycles; lat_en_n low exactly 2 cycles; done pulse; q_shadow=8'h20.
2. Reset write: req[2]=1, op=0, idx=5 after test 1 -> lat_r=8'h20, lat_s=0; q_shadow=8'h00.
3. Round-robin fairness: req=4'b1111 held continuously, each requester dropping its bit after its gnt -> grant order 0,1,2,3 with gnts exactly 5 cycles apart; then req=4'b0101 with pointer=0 -> grants 0 then 2.
4. Out-of-range index: NLAT=6, idx=7 -> err pulses in SETUP; lat_s=lat_r=0 throughout; done still pulses; q_shadow unchanged.
5. Reset mid-PULSE: drop rst_n while lat_en_n=0 -> same cycle lat_en_n=1, lat_s=lat_r=0, q_shadow=0; after release the FSM is in IDLE and the pointer is 0.
6. Invariant check: random req/op/idx for 2000 cycles -> assertions never fire: (lat_s&lat_r)==0, $onehot0(gnt), s/r stable while lat_en_n=0; q_shadow matches a reference model.

Source files
------------

// File: rtl/sr_latch_bank_arbiter.sv
// Round-robin arbiter that serialises set/reset writes into a shared bank of
// active-low-enabled SR latches and keeps a registered shadow of their state.
module sr_latch_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int NLAT  = 8,
    parameter int IDXW  = 3,
    parameter int PULSE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_op,
    input  logic [NREQ*IDXW-1:0] req_idx,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [NLAT-1:0]      lat_s,
    output logic [NLAT-1:0]      lat_r,
    output logic                 lat_en_n,
    output logic [NLAT-1:0]      q_shadow
);

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNTW = (PULSE > 1) ? $clog2(PULSE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD
    } state_t;

    state_t           state, state_nxt;
    logic [PTRW-1:0]  ptr, ptr_nxt;
    logic [CNTW-1:0]  cnt, cnt_nxt;
    logic             cur_op, cur_op_nxt;
    logic [IDXW-1:0]  cur_idx, cur_idx_nxt;
    logic             cur_oor, cur_oor_nxt;

    logic [NREQ-1:0]  gnt_nxt;
    logic             busy_nxt, done_nxt, err_nxt, lat_en_n_nxt;
    logic [NLAT-1:0]  lat_s_nxt, lat_r_nxt, q_shadow_nxt;

    logic             sel_found;
    logic [PTRW-1:0]  sel_k;
    int unsigned      cand;

    // First active requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        sel_found = 1'b0;
        sel_k     = '0;
        cand      = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = (32'(ptr) + i) % NREQ;
            if (!sel_found && req[PTRW'(cand)]) begin
                sel_found = 1'b1;
                sel_k     = PTRW'(cand);
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        cnt_nxt      = cnt;
        cur_op_nxt   = cur_op;
        cur_idx_nxt  = cur_idx;
        cur_oor_nxt  = cur_oor;
        gnt_nxt      = '0;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        lat_en_n_nxt = 1'b1;
        lat_s_nxt    = lat_s;
        lat_r_nxt    = lat_r;
        q_shadow_nxt = q_shadow;

        case (state)
            S_IDLE: begin
                lat_s_nxt = '0;
                lat_r_nxt = '0;
                if (sel_found) begin
                    state_nxt     = S_SETUP;
                    gnt_nxt[sel_k] = 1'b1;
                    ptr_nxt       = (32'(sel_k) == NREQ - 1) ? '0 : sel_k + 1'b1;
                    cur_op_nxt    = req_op[sel_k];
                    cur_idx_nxt   = req_idx[int'(sel_k)*IDXW +: IDXW];
                    cur_oor_nxt   = (32'(cur_idx_nxt) >= NLAT);
                    err_nxt       = cur_oor_nxt;
                    // s/r are decided here so they are already stable in SETUP
                    if (!cur_oor_nxt) begin
                        lat_s_nxt[cur_idx_nxt] = cur_op_nxt;
                        lat_r_nxt[cur_idx_nxt] = ~cur_op_nxt;
                    end
                end
            end
            S_SETUP: begin
                state_nxt    = S_PULSE;
                cnt_nxt      = '0;
                lat_en_n_nxt = 1'b0;
            end
            S_PULSE: begin
                if (32'(cnt) == PULSE - 1) begin
                    state_nxt = S_HOLD;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt      = cnt + 1'b1;
                    lat_en_n_nxt = 1'b0;
                end
            end
            S_HOLD: begin
                state_nxt = S_IDLE;
                lat_s_nxt = '0;
                lat_r_nxt = '0;
                if (!cur_oor) begin
                    q_shadow_nxt[cur_idx] = cur_op;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                lat_s_nxt = '0;
                lat_r_nxt = '0;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ptr      <= '0;
            cnt      <= '0;
            cur_op   <= 1'b0;
            cur_idx  <= '0;
            cur_oor  <= 1'b0;
            gnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            lat_s    <= '0;
            lat_r    <= '0;
            lat_en_n <= 1'b1;
            q_shadow <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            cnt      <= cnt_nxt;
            cur_op   <= cur_op_nxt;
            cur_idx  <= cur_idx_nxt;
            cur_oor  <= cur_oor_nxt;
            gnt      <= gnt_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
            lat_s    <= lat_s_nxt;
            lat_r    <= lat_r_nxt;
            lat_en_n <= lat_en_n_nxt;
            q_shadow <= q_shadow_nxt;
        end
    end

endmodule

// File: tb/tb_sr_latch_bank_arbiter.sv
// Bench for sr_latch_bank_arbiter: vector table and hand sequences feed a
// scoreboard that a negedge monitor drains, plus per-cycle bank invariants.
module tb_sr_latch_bank_arbiter;

    localparam int NREQ  = 4;
    localparam int NLAT  = 8;
    localparam int IDXW  = 3;
    localparam int PULSE = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req, req_op;
    logic [NREQ*IDXW-1:0] req_idx;

    logic [NREQ-1:0] gnt;
    logic            busy, done, err, lat_en_n;
    logic [NLAT-1:0] lat_s, lat_r, q_shadow;

    logic [NREQ-1:0] gnt6;
    logic            busy6, done6, err6, lat_en_n6;
    logic [5:0]      lat_s6, lat_r6, q_shadow6;

    sr_latch_bank_arbiter #(.NREQ(NREQ), .NLAT(NLAT), .IDXW(IDXW), .PULSE(PULSE)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_idx(req_idx),
        .gnt(gnt), .busy(busy), .done(done), .err(err), .lat_s(lat_s), .lat_r(lat_r),
        .lat_en_n(lat_en_n), .q_shadow(q_shadow)
    );

    // Narrow bank with the same index width, so index 6 and 7 are out of range.
    sr_latch_bank_arbiter #(.NREQ(NREQ), .NLAT(6), .IDXW(IDXW), .PULSE(PULSE)) dut6 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_idx(req_idx),
        .gnt(gnt6), .busy(busy6), .done(done6), .err(err6), .lat_s(lat_s6), .lat_r(lat_r6),
        .lat_en_n(lat_en_n6), .q_shadow(q_shadow6)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] s;
        logic [7:0] r;
        logic [7:0] sh;
    } exp_t;

    typedef struct {
        int         k;
        bit         op;
        logic [2:0] idx;
        logic [7:0] s;
        logic [7:0] r;
        logic [7:0] sh;
    } vec_t;

    exp_t sb[$];
    exp_t cur;
    logic have_cur = 1'b0, sh_pending = 1'b0, pvalid = 1'b0, pen = 1'b1;
    logic [7:0] ps = '0, pr = '0;
    int gnt_cyc = 0, en_low = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            have_cur   = 1'b0;
            sh_pending = 1'b0;
            pvalid     = 1'b0;
        end else begin
            check("s_and_r_zero", 32'(lat_s & lat_r), 0);
            check("gnt_onehot0", 32'($onehot0(gnt)), 1);
            check("sr_onehot0", 32'($onehot0(lat_s | lat_r)), 1);
            if (pvalid && (!lat_en_n || !pen)) begin
                check("s_stable_en", 32'(lat_s), 32'(ps));
                check("r_stable_en", 32'(lat_r), 32'(pr));
            end
            if (sh_pending) begin
                check("q_shadow", 32'(q_shadow), 32'(cur.sh));
                sh_pending = 1'b0;
            end
            if (!lat_en_n) en_low++;
            if (gnt != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_gnt", 32'(gnt), 0);
                end else begin
                    cur      = sb.pop_front();
                    have_cur = 1'b1;
                    gnt_cyc  = cyc;
                    en_low   = 0;
                    check("gnt", 32'(gnt), 32'(cur.gnt));
                    check("setup_s", 32'(lat_s), 32'(cur.s));
                    check("setup_r", 32'(lat_r), 32'(cur.r));
                    check("setup_en_n", 32'(lat_en_n), 1);
                    check("setup_busy", 32'(busy), 1);
                    check("setup_err", 32'(err), 0);
                end
            end
            if (done) begin
                if (!have_cur) begin
                    check("unexpected_done", 32'(done), 0);
                end else begin
                    check("done_latency", 32'(cyc - gnt_cyc), PULSE + 1);
                    check("hold_s", 32'(lat_s), 32'(cur.s));
                    check("hold_r", 32'(lat_r), 32'(cur.r));
                    check("hold_en_n", 32'(lat_en_n), 1);
                    check("en_low_cycles", 32'(en_low), PULSE);
                    sh_pending = 1'b1;
                    have_cur   = 1'b0;
                end
            end
            ps     = lat_s;
            pr     = lat_r;
            pen    = lat_en_n;
            pvalid = 1'b1;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        sb.delete();
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic push_exp(input logic [3:0] g, input logic [7:0] s, input logic [7:0] r,
                            input logic [7:0] sh);
        exp_t e;
        e.gnt = g;
        e.s   = s;
        e.r   = r;
        e.sh  = sh;
        sb.push_back(e);
    endtask

    task automatic write_one(input int k, input bit op, input logic [2:0] idx,
                             input logic [7:0] es, input logic [7:0] er, input logic [7:0] esh);
        int n = 0;
        push_exp(4'(1 << k), es, er, esh);
        req_op[k]          = op;
        req_idx[k*3 +: 3]  = idx;
        req[k]             = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt[k] && n < 20);
        if (!gnt[k]) begin
            check("gnt_timeout", 32'(gnt), 32'(1 << k));
            req[k] = 1'b0;
            sb.delete();
            return;
        end
        // Changing op/idx after the grant must not disturb the write in flight.
        req[k]            = 1'b0;
        req_op[k]         = ~op;
        req_idx[k*3 +: 3] = ~idx;
        repeat (3) @(negedge clk);
        check("done_pulse", 32'(done), 1);
        @(negedge clk);
    endtask

    task automatic run_multi(input logic [3:0] mask);
        int n = 0;
        int last = -1;
        req = mask;
        while (req != '0 && n < 60) begin
            @(negedge clk);
            n++;
            if ((gnt & req) != '0) begin
                if (last >= 0) check("gnt_spacing", 32'(cyc - last), PULSE + 3);
                last = cyc;
                req  = req & ~gnt;
            end
        end
        check("multi_all_granted", 32'(req), 0);
        req = '0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    vec_t vecs[7];
    logic [7:0] model;
    logic [5:0] snap6;
    int n;
    bit rop;
    logic [2:0] ridx;
    int rk;
    logic [7:0] es, er;

    initial begin
        vecs[0] = '{0, 1'b1, 3'd5, 8'h20, 8'h00, 8'h20};
        vecs[1] = '{2, 1'b0, 3'd5, 8'h00, 8'h20, 8'h00};
        vecs[2] = '{1, 1'b1, 3'd0, 8'h01, 8'h00, 8'h01};
        vecs[3] = '{3, 1'b1, 3'd7, 8'h80, 8'h00, 8'h81};
        vecs[4] = '{0, 1'b1, 3'd7, 8'h80, 8'h00, 8'h81};
        vecs[5] = '{2, 1'b0, 3'd0, 8'h00, 8'h01, 8'h80};
        vecs[6] = '{1, 1'b1, 3'd3, 8'h08, 8'h00, 8'h88};

        req     = '0;
        req_op  = '0;
        req_idx = '0;
        rst_n   = 1'b0;
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_lat_s", 32'(lat_s), 0);
        check("rst_lat_r", 32'(lat_r), 0);
        check("rst_en_n", 32'(lat_en_n), 1);
        check("rst_shadow", 32'(q_shadow), 0);
        do_reset();

        // Single writes from the vector table
        for (int i = 0; i < 7; i++)
            write_one(vecs[i].k, vecs[i].op, vecs[i].idx, vecs[i].s, vecs[i].r, vecs[i].sh);

        // Out-of-range index on the 6-latch bank; the 8-latch bank takes a valid write
        snap6 = q_shadow6;
        push_exp(4'b0010, 8'h80, 8'h00, 8'h88);
        req_op[1]   = 1'b1;
        req_idx[5:3] = 3'd7;
        req[1]      = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt6[1] && n < 20);
        check("oor_gnt", 32'(gnt6), 32'(4'b0010));
        check("oor_err", 32'(err6), 1);
        check("oor_setup_s", 32'(lat_s6), 0);
        check("oor_setup_r", 32'(lat_r6), 0);
        req[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("oor_s", 32'(lat_s6), 0);
            check("oor_r", 32'(lat_r6), 0);
            check("oor_err_pulse", 32'(err6), 0);
        end
        check("oor_done", 32'(done6), 1);
        @(negedge clk);
        check("oor_shadow", 32'(q_shadow6), 32'(snap6));

        // Round-robin from pointer 0
        do_reset();
        req_op  = 4'b0111;
        req_idx = {3'd0, 3'd2, 3'd1, 3'd0};
        push_exp(4'b0001, 8'h01, 8'h00, 8'h01);
        push_exp(4'b0010, 8'h02, 8'h00, 8'h03);
        push_exp(4'b0100, 8'h04, 8'h00, 8'h07);
        push_exp(4'b1000, 8'h00, 8'h01, 8'h06);
        run_multi(4'b1111);
        req_op  = 4'b0001;
        req_idx = {3'd0, 3'd1, 3'd0, 3'd7};
        push_exp(4'b0001, 8'h80, 8'h00, 8'h86);
        push_exp(4'b0100, 8'h00, 8'h02, 8'h84);
        run_multi(4'b0101);

        // Reset in the middle of the enable pulse
        do_reset();
        write_one(0, 1'b1, 3'd2, 8'h04, 8'h00, 8'h04);
        push_exp(4'b0100, 8'h40, 8'h00, 8'h44);
        req_op[2]    = 1'b1;
        req_idx[8:6] = 3'd6;
        req[2]       = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt[2] && n < 20);
        check("mid_gnt", 32'(gnt), 32'(4'b0100));
        req[2] = 1'b0;
        @(negedge clk);
        check("mid_pulse_en_low", 32'(lat_en_n), 0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_en_n", 32'(lat_en_n), 1);
        check("mid_rst_s", 32'(lat_s), 0);
        check("mid_rst_r", 32'(lat_r), 0);
        check("mid_rst_shadow", 32'(q_shadow), 0);
        check("mid_rst_busy", 32'(busy), 0);
        sb.delete();
        @(negedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 32'(busy), 0);
        req_op  = 4'b0010;
        req_idx = {3'd1, 3'd0, 3'd1, 3'd0};
        push_exp(4'b0010, 8'h02, 8'h00, 8'h02);
        push_exp(4'b1000, 8'h00, 8'h02, 8'h00);
        run_multi(4'b1010);

        // Random single writes against a bench shadow model
        do_reset();
        model = '0;
        for (int i = 0; i < 300; i++) begin
            rk   = int'($urandom_range(0, 3));
            rop  = 1'($urandom_range(0, 1));
            ridx = 3'($urandom_range(0, 7));
            for (int j = 0; j < NREQ; j++) begin
                if (j != rk) begin
                    req_op[j]         = 1'($urandom_range(0, 1));
                    req_idx[j*3 +: 3] = 3'($urandom_range(0, 7));
                end
            end
            es = '0;
            er = '0;
            es[ridx] = rop;
            er[ridx] = ~rop;
            model[ridx] = rop;
            write_one(rk, rop, ridx, es, er, model);
        end

        check("sb_drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
